// File: rtl/gnss_code_mem_pkg.sv
// -----------------------------------------------------------------------------
// gnss_code_mem_pkg
//
// Purpose : Shared definitions for the GNSS spreading-code table memory.
//           Holds the default sizing (channels, code length, chip-index width),
//           a ceiling-log2 helper usable in parameter expressions, and the
//           next-chip wrap arithmetic used when prefetching the upcoming chip.
//
// Contents: DEF_CHANS, DEF_CODELEN, DEF_CODEBITS  default sizing
//           clog2(value)                          ceil(log2(value)), min 1
//           next_chip(chip, codelen)              chip+1 with wrap to 0
// -----------------------------------------------------------------------------
package gnss_code_mem_pkg;

   // Ceiling log2, never below 1 so a one-entry table still gets a real
   // index bit.
   function automatic int clog2(input int value);
      int bits;
      bits = 0;
      for (int v = 1; v < value; v = v * 2) begin
         bits = bits + 1;
      end
      return (bits < 1) ? 1 : bits;
   endfunction

   // Index of the chip that follows 'chip' in a code of 'codelen' chips.
   // Any out-of-range index is folded back to chip 0 as well, so a bad
   // channel setting can never address past the end of the table.
   function automatic int next_chip(input int chip, input int codelen);
      return (chip >= codelen - 1) ? 0 : chip + 1;
   endfunction

   localparam int DEF_CHANS    = 12;
   localparam int DEF_CODELEN  = 4092;
   localparam int DEF_CODEBITS = clog2(DEF_CODELEN);

endpackage

// File: rtl/gnss_code_ram.sv
// -----------------------------------------------------------------------------
// gnss_code_ram
//
// Purpose : Simple dual-port code table, DEPTH words of WIDTH bits.
//           One write port and one synchronous read port on the same clock.
//           A read of the word being written in the same cycle returns the
//           old contents (read-first). Contents are never cleared by reset.
//
// Ports   : clk    in   sole clock, posedge
//           we     in   write enable
//           waddr  in   write address [ABITS]
//           wdata  in   write data [WIDTH]
//           raddr  in   read address [ABITS]
//           rdata  out  registered read data [WIDTH], valid the cycle after
//                       raddr is presented
// -----------------------------------------------------------------------------
module gnss_code_ram
   import gnss_code_mem_pkg::*;
#(
   parameter int WIDTH = DEF_CHANS,
   parameter int DEPTH = DEF_CODELEN,
   parameter int ABITS = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [ABITS-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [ABITS-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Both ports sampled on the same edge; the read sees the pre-write value.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/gnss_code_mem.sv
// -----------------------------------------------------------------------------
// gnss_code_mem
//
// Purpose : Shared spreading-code table for CHANS tracking channels.
//           Each memory word holds one chip per channel (bit c = channel c).
//           A round-robin slot counter visits one channel per cycle and
//           prefetches the chip that channel will need next, so that on a
//           chip-advance strobe the new chip is available combinationally.
//
// Build option:
//           GNSS_CODE_UNDERRUN_EN  when defined, builds per-channel prefetch
//                                  valid tracking and sticky underrun flags.
//                                  When undefined, underrun is tied to 0.
//
// Ports   : clk           in   sole clock, posedge
//           rst           in   synchronous active-high reset (memory kept)
//           wr            in   write one code word per cycle
//           wr_rewind     in   return the write pointer to word 0
//           tos           in   [CHANS] write data, bit c = channel c chip
//           nchip_n       in   [CHANS*CODEBITS] packed current chip indices
//           full_chip     in   [CHANS] per-channel chip-advance strobe
//           code_o        out  [CHANS] current chip value per channel
//           loaded        out  whole table written since last rst/rewind
//           underrun      out  [CHANS] sticky prefetch-miss flags
//           underrun_clr  in   clear all underrun flags
// -----------------------------------------------------------------------------
module gnss_code_mem
   import gnss_code_mem_pkg::*;
#(
   parameter int CHANS    = DEF_CHANS,
   parameter int CODELEN  = DEF_CODELEN,
   parameter int CODEBITS = clog2(CODELEN)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr,
   input  logic                      wr_rewind,
   input  logic [CHANS-1:0]          tos,
   input  logic [CHANS*CODEBITS-1:0] nchip_n,
   input  logic [CHANS-1:0]          full_chip,
   output logic [CHANS-1:0]          code_o,
   output logic                      loaded,
   output logic [CHANS-1:0]          underrun,
   input  logic                      underrun_clr
);

   localparam int                  SLOTBITS  = clog2(CHANS);
   localparam logic [CODEBITS-1:0] WLAST     = CODEBITS'(CODELEN - 1);
   localparam logic [SLOTBITS-1:0] SLOT_LAST = SLOTBITS'(CHANS - 1);

   // ---------------------------------------------------------------------
   // Write side: linear fill of the code table
   // ---------------------------------------------------------------------
   logic [CODEBITS-1:0] waddr;
   logic                mem_we;

   // A write strobe coinciding with reset is dropped entirely.
   assign mem_we = wr && !rst;

   // Rewind dominates a simultaneous write for the pointer and the loaded
   // flag; the word strobed in that cycle still lands at the old pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         waddr  <= '0;
         loaded <= 1'b0;
      end else if (wr_rewind) begin
         waddr  <= '0;
         loaded <= 1'b0;
      end else if (wr) begin
         if (waddr == WLAST) begin
            waddr  <= '0;
            loaded <= 1'b1;
         end else begin
            waddr  <= waddr + CODEBITS'(1);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Read side: round-robin slot scheduler
   // ---------------------------------------------------------------------
   logic [SLOTBITS-1:0] slot;

   always_ff @(posedge clk) begin
      if (rst) begin
         slot <= '0;
      end else if (slot == SLOT_LAST) begin
         slot <= '0;
      end else begin
         slot <= slot + SLOTBITS'(1);
      end
   end

   // Stage p0: choose the channel two slots ahead, since its data is only
   // captured two cycles later, and form the address of its next chip.
   logic [SLOTBITS-1:0] ch_p0;
   logic [CODEBITS-1:0] nchip_p0;
   logic [CODEBITS-1:0] raddr_p0;

   always_comb begin
      ch_p0    = SLOTBITS'((int'(slot) + 2) % CHANS);
      nchip_p0 = nchip_n[int'(ch_p0) * CODEBITS +: CODEBITS];
      raddr_p0 = CODEBITS'(next_chip(int'(nchip_p0), CODELEN));
   end

   logic [CHANS-1:0] rdata_p1;

   gnss_code_ram #(
      .WIDTH (CHANS),
      .DEPTH (CODELEN),
      .ABITS (CODEBITS)
   ) u_ram (
      .clk   (clk),
      .we    (mem_we),
      .waddr (waddr),
      .wdata (tos),
      .raddr (raddr_p0),
      .rdata (rdata_p1)
   );

   // Stage p1: RAM output valid; carry the channel tag alongside it.
   // vld_p1 suppresses a capture from the read issued during reset.
   logic [SLOTBITS-1:0] ch_p1;
   logic                vld_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= 1'b1;
      end
      ch_p1 <= ch_p0;
   end

   // One-hot capture strobe for the channel whose word is on rdata_p1.
   logic [CHANS-1:0] cap_p1;

   always_comb begin
      cap_p1 = '0;
      if (vld_p1) begin
         cap_p1[ch_p1] = 1'b1;
      end
   end

   // Stage p2: per-channel prefetch and held chip registers.
   logic [CHANS-1:0] prefetch;
   logic [CHANS-1:0] code_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         prefetch <= '0;
         code_q   <= '0;
      end else begin
         for (int c = 0; c < CHANS; c++) begin
            if (cap_p1[c]) begin
               prefetch[c] <= rdata_p1[c];
            end
            if (full_chip[c]) begin
               code_q[c] <= prefetch[c];
            end
         end
      end
   end

   // On the advance strobe the new chip bypasses code_q so the tracking
   // loop sees it in the same cycle; afterwards code_q holds it.
   assign code_o = (full_chip & prefetch) | (~full_chip & code_q);

   // ---------------------------------------------------------------------
   // Prefetch-miss detection
   // ---------------------------------------------------------------------
`ifdef GNSS_CODE_UNDERRUN_EN
   logic [CHANS-1:0] pf_valid;
   logic [CHANS-1:0] underrun_q;

   // A capture in the same cycle as the advance strobe wins, so the freshly
   // fetched chip is treated as valid for the following advance.
   // A new miss in the same cycle as a clear wins, so no event is lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         pf_valid   <= '0;
         underrun_q <= '0;
      end else begin
         pf_valid   <= cap_p1 | (pf_valid & ~full_chip);
         underrun_q <= (full_chip & ~pf_valid)
                     | (underrun_q & ~{CHANS{underrun_clr}});
      end
   end

   assign underrun = underrun_q;
`else
   logic unused_clr;

   assign unused_clr = underrun_clr;
   assign underrun   = '0;
`endif

endmodule

// File: tb/tb_gnss_code_mem.sv
module tb_gnss_code_mem;

   localparam int CHANS    = 4;
   localparam int CODELEN  = 8;
   localparam int CODEBITS = 3;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      wr;
   logic                      wr_rewind;
   logic [CHANS-1:0]          tos;
   logic [CHANS*CODEBITS-1:0] nchip_n;
   logic [CHANS-1:0]          full_chip;
   logic [CHANS-1:0]          code_o;
   logic                      loaded;
   logic [CHANS-1:0]          underrun;
   logic                      underrun_clr;

   int tests = 0;
   int fails = 0;

   logic [31:0]      exp_q [$];
   logic [CHANS-1:0] model [CODELEN];
   int               bwaddr = 0;
   int               bslot  = 0;

   always #5 clk = ~clk;

   gnss_code_mem #(
      .CHANS    (CHANS),
      .CODELEN  (CODELEN),
      .CODEBITS (CODEBITS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wr           (wr),
      .wr_rewind    (wr_rewind),
      .tos          (tos),
      .nchip_n      (nchip_n),
      .full_chip    (full_chip),
      .code_o       (code_o),
      .loaded       (loaded),
      .underrun     (underrun),
      .underrun_clr (underrun_clr)
   );

   // Reference round-robin slot, used only to place strobes on a known phase.
   always @(posedge clk) begin
      bslot <= rst ? 0 : (bslot + 1) % CHANS;
   end

   function automatic int nxt(input int n);
      return (n == CODELEN - 1) ? 0 : n + 1;
   endfunction

   task automatic push_exp(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $error("FAIL %s: observed=%0h but no expected value queued", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, e);
         end
      end
   endtask

   // Called just after a negedge; returns just after the following negedge.
   task automatic write_word(input logic [CHANS-1:0] d);
      wr  = 1'b1;
      tos = d;
      model[bwaddr] = d;
      bwaddr = nxt(bwaddr);
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic probe(input string tag, input int c, input int n);
      logic e;
      nchip_n[c*CODEBITS +: CODEBITS] = CODEBITS'(n);
      repeat (CHANS + 3) @(negedge clk);
      e = model[nxt(n)][c];
      push_exp({31'b0, e});
      full_chip[c] = 1'b1;
      #1;
      check({tag, "_now"}, {31'b0, code_o[c]});
      push_exp({31'b0, e});
      @(negedge clk);
      full_chip[c] = 1'b0;
      #1;
      check({tag, "_held"}, {31'b0, code_o[c]});
      repeat (CHANS + 2) @(negedge clk);
   endtask

   initial begin
      rst          = 1'b1;
      wr           = 1'b0;
      wr_rewind    = 1'b0;
      tos          = '0;
      nchip_n      = '0;
      full_chip    = '0;
      underrun_clr = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      push_exp(32'd0); check("rst_code_o",   {28'b0, code_o});
      push_exp(32'd0); check("rst_loaded",   {31'b0, loaded});
      push_exp(32'd0); check("rst_underrun", {28'b0, underrun});
      push_exp(32'd0); check("rst_waddr",    {29'b0, dut.waddr});
      @(negedge clk);

      // Full table load: word i = i.
      for (int i = 0; i < CODELEN; i++) begin
         write_word(CHANS'(i % 16));
         if (i == CODELEN - 2) begin
            push_exp(32'd0); check("loaded_before_last", {31'b0, loaded});
         end
      end
      push_exp(32'd1); check("loaded_after_last", {31'b0, loaded});
      push_exp(32'd0); check("waddr_wrapped",     {29'b0, dut.waddr});

      // Chip prefetch including the wrap from chip CODELEN-1 to 0.
      probe("ch2_wrap", 2, 7);
      probe("ch0_n0",   0, 0);
      probe("ch1_n1",   1, 1);
      probe("ch2_n3",   2, 3);
      probe("ch3_n6",   3, 6);
      push_exp(32'd0); check("no_underrun_spaced", {28'b0, underrun});

      // Close-spaced advances on channel 1: first on slot 1, second 3 cycles
      // later, just before the refill of channel 1 lands.
      for (int k = 0; k < 2 * CHANS && bslot != 1; k++) @(negedge clk);
      full_chip[1] = 1'b1;
      @(negedge clk);
      full_chip[1] = 1'b0;
      repeat (2) @(negedge clk);
      full_chip[1] = 1'b1;
      @(negedge clk);
      full_chip[1] = 1'b0;
      #1;
`ifdef GNSS_CODE_UNDERRUN_EN
      push_exp(32'b0010);
`else
      push_exp(32'b0000);
`endif
      check("underrun_close", {28'b0, underrun});
      @(negedge clk);
      underrun_clr = 1'b1;
      @(negedge clk);
      underrun_clr = 1'b0;
      #1;
      push_exp(32'd0); check("underrun_cleared", {28'b0, underrun});
      @(negedge clk);

      // Rewind clears loaded; then a partial load and write+rewind together.
      wr_rewind = 1'b1;
      @(negedge clk);
      wr_rewind = 1'b0;
      bwaddr = 0;
      push_exp(32'd0); check("rewind_loaded", {31'b0, loaded});
      for (int i = 0; i < 5; i++) write_word(CHANS'(i));
      push_exp(32'd5); check("waddr_five", {29'b0, dut.waddr});
      wr        = 1'b1;
      wr_rewind = 1'b1;
      tos       = CHANS'(5);
      @(negedge clk);
      wr        = 1'b0;
      wr_rewind = 1'b0;
      bwaddr    = 0;
      push_exp(32'd0); check("wr_rewind_waddr",  {29'b0, dut.waddr});
      push_exp(32'd0); check("wr_rewind_loaded", {31'b0, loaded});

      // Reload the full table, then overwrite three words and reset mid-load.
      for (int i = 0; i < CODELEN; i++) write_word(CHANS'(i % 16));
      push_exp(32'd1); check("reload_loaded", {31'b0, loaded});
      write_word(4'hA);
      write_word(4'h5);
      write_word(4'hC);
      probe("ch0_new_w1", 0, 0);
      rst = 1'b1;
      wr  = 1'b1;
      tos = 4'hF;
      @(negedge clk);
      rst = 1'b0;
      wr  = 1'b0;
      #1;
      push_exp(32'd0); check("midload_rst_waddr",  {29'b0, dut.waddr});
      push_exp(32'd0); check("midload_rst_loaded", {31'b0, loaded});
      push_exp(32'd0); check("midload_rst_code_o", {28'b0, code_o});
      @(negedge clk);

      // Memory survives reset; the write strobed during reset was dropped.
      probe("ch2_w1_kept", 2, 0);
      probe("ch3_w2_kept", 3, 1);
      probe("ch1_w2_kept", 1, 1);
      probe("ch1_w3_kept", 1, 2);
      probe("ch2_w0_kept", 2, 7);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gnss_code_mem.md
GNSS_CODE_MEM -- requirements
Module: gnss_code_mem

Interface
REQ-001 SHALL have parameter CHANS, default 12: number of tracking channels and memory word width in bits (1..32).
REQ-002 SHALL have parameter CODELEN, default 4092: chips per code period; memory depth.
REQ-003 SHALL have parameter CODEBITS, default clog2(CODELEN): chip-index width.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port wr, input, 1: write strobe, one memory word per cycle.
REQ-007 SHALL have port wr_rewind, input, 1: return the write pointer to word 0.
REQ-008 SHALL have port tos, input, CHANS: write data; bit c is channel c's chip.
REQ-009 SHALL have port nchip_n, input, CHANS*CODEBITS: packed current chip index, channel c at [c*CODEBITS +: CODEBITS].
REQ-010 SHALL have port full_chip, input, CHANS: per-channel chip-advance strobe.
REQ-011 SHALL have port code_o, output, CHANS: current chip value per channel.
REQ-012 SHALL have port loaded, output, 1: full code table written.
REQ-013 SHALL have port underrun, output, CHANS: sticky per-channel prefetch-miss flags.
REQ-014 SHALL have port underrun_clr, input, 1: clears all underrun flags.

Function
REQ-015 SHALL hold waddr (CODEBITS): +1 per wr; CODELEN-1 wraps to 0; wr_rewind forces 0 and wins over a simultaneous wr.
REQ-016 SHALL set loaded when a wr lands at waddr CODELEN-1; only rst or wr_rewind clears it.
REQ-017 SHALL use a round-robin slot counter 0..CHANS-1, advancing one per cycle, wrapping to 0.
REQ-018 In slot s, SHALL issue read address next(nchip[(s+2) mod CHANS]), where next(CODELEN-1)=0 and next(n)=n+1; the +2 offsets the two-cycle read pipeline.
REQ-019 Memory data SHALL be valid one cycle after the address; the following cycle SHALL capture bit (s+2) mod CHANS into that channel's prefetch register and set its pf_valid.
REQ-020 When full_chip[c] is high, code_o[c] SHALL equal prefetch[c] combinationally in that cycle; the cycle after, code_o[c] SHALL hold that value until the next full_chip[c].
REQ-021 full_chip[c] SHALL clear pf_valid[c]; a prefetch capture into c in the same cycle SHALL win and leave pf_valid[c] set.
REQ-022 full_chip[c] with pf_valid[c]=0 SHALL set underrun[c]; code_o[c] still takes the stale prefetch.
REQ-023 underrun_clr SHALL clear all flags; a simultaneous new underrun SHALL win.
REQ-024 Reads and writes SHALL proceed concurrently; a read to the address being written returns old data (read-first).
REQ-025 Successive full_chip[c] SHALL be at least CHANS+2 cycles apart; closer spacing is reported, not prevented, via REQ-022.

Reset
REQ-026 rst SHALL zero waddr, the slot counter, all prefetch registers, pf_valid, code_o, underrun and loaded; memory contents SHALL be kept.
REQ-027 rst mid-load SHALL leave waddr at 0, so a reload restarts cleanly; wr during rst SHALL be ignored.

Configuration
REQ-028 With GNSS_CODE_UNDERRUN_EN defined, REQ-021..REQ-023 logic SHALL be built.
REQ-029 Without GNSS_CODE_UNDERRUN_EN, underrun SHALL be tied to 0, pf_valid SHALL not exist, and all other behaviour is unchanged.

Structure
REQ-030 The shared package SHALL hold next-chip wrap arithmetic, clog2, and defaults for CHANS, CODELEN and CODEBITS.
REQ-031 Storage SHALL be one sub-module, gnss_code_ram: simple dual-port, synchronous read, CODELEN x CHANS, read-first.

Verification
REQ-032 CHANS=4, CODELEN=8, rst, then 8 wr of tos=c mod 16 -> loaded=1 after 8th wr; waddr=0.
REQ-033 Channel 2 with nchip=7 -> prefetch reads word 0; full_chip[2] gives code_o[2]=bit2 of word 0 in the same cycle.
REQ-034 wr and wr_rewind in the same cycle at waddr=5 -> waddr=0; loaded unchanged.
REQ-035 full_chip[1] twice, 3 cycles apart (CHANS=4) -> underrun[1]=1; underrun_clr -> 0.
REQ-036 rst after 3 wr -> waddr=0, loaded=0, code_o=0; earlier words still readable.
REQ-037 Build without GNSS_CODE_UNDERRUN_EN and rerun REQ-035 -> underrun stays 0; code_o matches REQ-033.
